l2_dmem_bank_pipe: RTL and testbench

Parametrised L2 data-memory bank with a valid/ready request/response interface and per-lane write masking, sitting between the dNoC L2 port and the tiled single-port SRAM macros. It generalises the fixed 256-bit × 1024-entry bank in width (lane count) and depth (rows of 1024×32 macros). It adds a credit-limited response queue so that the consumer can apply back-pressure without losing read data.

---
 rtl/l2_dmem_pkg.sv | 21 ++
 rtl/l2_dmem_rsp_fifo.sv | 41 ++++
 rtl/l2_dmem_sram_1024x32.sv | 25 ++
 rtl/l2_dmem_bank_pipe.sv | 152 +++++++++++++++
 tb/tb_l2_dmem_bank_pipe.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_dmem_pkg.sv
// rtl/l2_dmem_pkg.sv - shared constants, types and helpers for the L2 data-memory bank
//
// Purpose : macro geometry, credit-counter width and the lane type used to build
//           response entries (lane_t [LANES-1:0]) in the bank and its FIFO.
// Ports   : none (package).
package l2_dmem_pkg;

  localparam int MACRO_DEPTH = 1024;
  localparam int MACRO_W     = 32;
  localparam int MACRO_AW    = $clog2(MACRO_DEPTH);

  // Wide enough for the largest outstanding-read count (3 with the output register).
  localparam int CREDIT_W = 2;

  typedef logic [MACRO_W-1:0] lane_t;

  function automatic int l2_dmem_rows(input int depth);
    return depth / MACRO_DEPTH;
  endfunction

endpackage

// File: rtl/l2_dmem_rsp_fifo.sv
// rtl/l2_dmem_rsp_fifo.sv - 2-entry response FIFO with same-cycle push/pop
//
// Purpose : holds read responses the consumer has not yet taken.
// Ports   : clk clock; rst sync active-high reset; push/wdata enqueue;
//           pop dequeue head; rdata current head; count entries held (0..2).
module l2_dmem_rsp_fifo
  import l2_dmem_pkg::*;
#(
  parameter int W = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        wdata,
  input  logic                pop,
  output logic [W-1:0]        rdata,
  output logic [CREDIT_W-1:0] count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + CREDIT_W'(push) - CREDIT_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/l2_dmem_sram_1024x32.sv
// rtl/l2_dmem_sram_1024x32.sv - 1024x32 single-port SRAM macro wrapper
//
// Purpose : behavioural view of the single-port macro; active-low chip and write
//           enables, registered read data that holds until the next read.
// Ports   : CLK clock; CEB chip enable (low); WEB write enable (low);
//           A word address; D write data; Q read data (valid the cycle after a read).
module l2_dmem_sram_1024x32 (
  input  logic        CLK,
  input  logic        CEB,
  input  logic        WEB,
  input  logic [9:0]  A,
  input  logic [31:0] D,
  output logic [31:0] Q
);

  logic [31:0] mem [1024];

  always_ff @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= D;
      else      Q      <= mem[A];
    end
  end

endmodule

// File: rtl/l2_dmem_bank_pipe.sv
// rtl/l2_dmem_bank_pipe.sv - parametrised L2 data-memory bank with credit-limited response queue
//
// Purpose : ROWS x LANES grid of 1024x32 single-port macros behind a valid/ready
//           request port with per-lane write masking, and an in-order response
//           port that tolerates consumer back-pressure.
// Ports   : CLK clock; RST sync active-high reset;
//           REQ_VALID/REQ_READY/REQ_WE/REQ_ADDR/REQ_WMASK/REQ_WDATA request;
//           RSP_VALID/RSP_READY/RSP_DATA read response (RSP_DATA is 0 when idle).
// Config  : L2_DMEM_BANK_OUTREG_EN registers the muxed macro output (read latency 2,
//           up to 3 reads outstanding). Undefined: latency 1, up to 2 outstanding.
module l2_dmem_bank_pipe
  import l2_dmem_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WE,
  input  logic [AW-1:0]       REQ_ADDR,
  input  logic [LANES-1:0]    REQ_WMASK,
  input  logic [LANES*32-1:0] REQ_WDATA,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [LANES*32-1:0] RSP_DATA
);

  localparam int ROWS = l2_dmem_rows(DEPTH);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW   = LANES * MACRO_W;

  typedef lane_t [LANES-1:0] rsp_entry_t;

  logic                     req_fire;
  logic                     rd_fire;
  logic [RW-1:0]            row_sel;
  logic [RW-1:0]            rd_row_q;
  logic [MACRO_AW-1:0]      mac_addr;
  logic [ROWS-1:0][DW-1:0]  row_q;
  rsp_entry_t               q_mux;
  logic                     pending;

  // Stage feeding the response logic: raw macro Q, or its registered copy.
  logic                     s_valid;
  rsp_entry_t               s_data;

  logic [CREDIT_W-1:0]      fifo_count;
  logic [CREDIT_W-1:0]      outstanding;
  logic [CREDIT_W-1:0]      outstanding_next;
  rsp_entry_t               fifo_head;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     bypass;
  logic                     rsp_fire;
  logic                     rsp_valid_int;

  assign req_fire = REQ_VALID & REQ_READY;
  assign rd_fire  = req_fire & ~REQ_WE;
  // Truncating shift keeps a single-row bank at row 0 without a zero-width slice.
  assign row_sel  = RW'(REQ_ADDR >> MACRO_AW);
  assign mac_addr = REQ_ADDR[MACRO_AW-1:0];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic row_ceb;
    assign row_ceb = ~(req_fire & (row_sel == RW'(r)));
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      l2_dmem_sram_1024x32 u_macro (
        .CLK (CLK),
        .CEB (row_ceb),
        .WEB (~(REQ_WE & REQ_WMASK[i])),
        .A   (mac_addr),
        .D   (REQ_WDATA[i*MACRO_W +: MACRO_W]),
        .Q   (row_q[r][i*MACRO_W +: MACRO_W])
      );
    end
  end

  // Row of the last read; writes leave it alone so a following write to
  // another row cannot redirect the mux away from the data being returned.
  always_ff @(posedge CLK) begin
    if (RST) pending <= 1'b0;
    else     pending <= rd_fire;
    if (rd_fire) rd_row_q <= row_sel;
  end

  always_comb begin
    q_mux = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rd_row_q == RW'(r)) q_mux = row_q[r];
    end
  end

`ifdef L2_DMEM_BANK_OUTREG_EN
  localparam int CREDITS = 3;

  logic       stage2_valid;
  rsp_entry_t stage2_data;
  logic       s_take;

  // Stage 2 only stalls when the FIFO is full and not popping; the credit
  // limit guarantees stage 1 is empty then, so no read data is lost.
  assign s_take = bypass | fifo_push;

  always_ff @(posedge CLK) begin
    if (RST)                        stage2_valid <= 1'b0;
    else if (!stage2_valid || s_take) stage2_valid <= pending;
    if (!stage2_valid || s_take)    stage2_data  <= q_mux;
  end

  assign s_valid     = stage2_valid;
  assign s_data      = stage2_data;
  assign outstanding = CREDIT_W'(pending) + CREDIT_W'(stage2_valid) + fifo_count;
`else
  localparam int CREDITS = 2;

  // Q is consumed (bypassed or queued) in the only cycle it is valid.
  assign s_valid     = pending;
  assign s_data      = q_mux;
  assign outstanding = CREDIT_W'(pending) + fifo_count;
`endif

  assign fifo_empty    = (fifo_count == '0);
  assign rsp_valid_int = ~RST & (s_valid | ~fifo_empty);
  assign rsp_fire      = rsp_valid_int & RSP_READY;
  assign fifo_pop      = rsp_fire & ~fifo_empty;
  assign bypass        = rsp_fire & fifo_empty;
  assign fifo_push     = ~RST & s_valid & ~bypass &
                         ((fifo_count < CREDIT_W'(2)) | fifo_pop);

  l2_dmem_rsp_fifo #(.W(DW)) u_rsp_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  // A pop this cycle frees a credit immediately, which is what sustains one
  // read per cycle while the consumer keeps RSP_READY high.
  assign outstanding_next = outstanding - CREDIT_W'(rsp_fire);
  assign REQ_READY = ~RST & (REQ_WE | (outstanding_next < CREDIT_W'(CREDITS)));

  assign RSP_VALID = rsp_valid_int;
  assign RSP_DATA  = !rsp_valid_int ? '0 : (fifo_empty ? s_data : fifo_head);

endmodule

// File: tb/tb_l2_dmem_bank_pipe.sv
// tb/tb_l2_dmem_bank_pipe.sv - scoreboard bench for l2_dmem_bank_pipe
module tb_l2_dmem_bank_pipe;

  localparam int LANES = 8;
  localparam int DEPTH = 4096;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = LANES * 32;
`ifdef L2_DMEM_BANK_OUTREG_EN
  localparam int LAT  = 2;
  localparam int CRED = 3;
`else
  localparam int LAT  = 1;
  localparam int CRED = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [LANES-1:0] req_wmask;
  logic [DW-1:0]    req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_data;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic [AW-1:0] stall_addr [4] = '{12'h003, 12'h403, 12'h803, 12'hC03};
  logic [31:0]   stall_val  [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  l2_dmem_bank_pipe #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_WE    (req_we),
    .REQ_ADDR  (req_addr),
    .REQ_WMASK (req_wmask),
    .REQ_WDATA (req_wdata),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_DATA  (rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fill(input logic [31:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] inc(input logic [31:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = b + 32'(i);
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT hands over a response.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got %h, required no response", rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data) begin
          errors++;
          $display("FAIL rsp_data: got %h required %h", rsp_data, e.data);
        end
        if (e.due >= 0) begin
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL rsp_latency: got cycle %0d required cycle %0d", cyc, e.due);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Presents one request until accepted; reads push their expected data.
  // tight=1 also requires immediate acceptance and exact response latency.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [LANES-1:0] m,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_d, input logic tight);
    int   n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got req_ready 0 required 1 at addr %h", a);
    end else begin
      if (tight) chk("req_no_wait", DW'(n), '0);
      if (!we) begin
        e.data = exp_d;
        e.due  = tight ? cyc + LAT : -1;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [DW-1:0] d);
    issue(1'b1, a, m, d, '0, 1'b1);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic tight);
    issue(1'b0, a, '1, '0, exp_d, tight);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wmask = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", DW'(req_ready), '0);
    chk("reset_rsp_valid", DW'(rsp_valid), '0);
    chk("reset_rsp_data", rsp_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-width write then read with latency check
    wr(12'h005, '1, inc(32'hA5A5_0000));
    rd(12'h005, inc(32'hA5A5_0000), 1'b1);
    drain();

    // Partial write mask: lanes 0 and 2 cleared
    wr(12'h010, '1, fill(32'hFFFF_FFFF));
    wr(12'h010, 8'h05, '0);
    rd(12'h010, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_00000000, 1'b1);
    drain();

    // One address per macro row, read back-to-back
    for (int k = 0; k < 4; k++) wr(stall_addr[k], '1, fill(stall_val[k]));
    for (int k = 0; k < 4; k++) rd(stall_addr[k], fill(stall_val[k]), 1'b1);
    drain();

    // Read-after-write and write-after-read on adjacent cycles
    wr(12'h007, '1, 256'h1);
    rd(12'h007, 256'h1, 1'b1);
    wr(12'h009, '1, fill(32'h9999_0000));
    rd(12'h009, fill(32'h9999_0000), 1'b1);
    wr(12'h009, '1, fill(32'hDEAD_BEEF));
    rd(12'h009, fill(32'hDEAD_BEEF), 1'b1);
    drain();

    // Back-pressure: credit limit blocks reads but not writes
    rsp_ready = 1'b0;
    for (int k = 0; k < CRED; k++) rd(stall_addr[k], fill(stall_val[k]), 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = stall_addr[CRED];
    repeat (3) begin
      @(negedge clk);
      chk("stall_read_blocked", DW'(req_ready), '0);
      chk("stall_rsp_valid", DW'(rsp_valid), DW'(1));
      chk("stall_rsp_hold", rsp_data, fill(32'h1111_1111));
    end
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_addr  = 12'h020;
    req_wmask = '1;
    req_wdata = fill(32'h5A5A_5A5A);
    @(negedge clk);
    chk("stall_write_accepted", DW'(req_ready), DW'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = CRED; k < 4; k++) rd(stall_addr[k], fill(stall_val[k]), 1'b0);
    drain();
    rd(12'h020, fill(32'h5A5A_5A5A), 1'b1);
    drain();

    // Reset with two reads outstanding drops them; memory survives
    rsp_ready = 1'b0;
    rd(12'h005, inc(32'hA5A5_0000), 1'b0);
    rd(12'h010, fill(32'h1234_5678), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_inflight_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_req_ready", DW'(req_ready), '0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", DW'(rsp_valid), '0);
    end
    @(posedge clk);
    #1;
    rd(12'h005, inc(32'hA5A5_0000), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
